arbiter_cascade: RTL and testbench
==================================

ARBITER_CASCADE -- requirements
Module: arbiter_cascade

Interface
REQ-001 Parameter: input_size, default 2, number of requester ports N; the block SHALL support any N >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-low.
REQ-004 req_in  input  N  request vector from the previous-stage blocks, one bit per requester.
REQ-005 ack_in  output  N  acknowledge vector to the previous-stage blocks, one bit per requester.
REQ-006 req_out  output  1  merged request to the next block.
REQ-007 ack_out  input  1  acknowledge from the next block.
REQ-008 sel  output  N  one-hot code of the granted requester; all zeros when no grant is held.

Function
REQ-009 All outputs SHALL be registered, with exactly one clk cycle of latency from the causing input sample.
REQ-010 Four-phase handshake on both sides:
- req rises, then ack rises;
- req falls, then ack falls.
REQ-011 FSM states SHALL be IDLE, REQ, ACK and REL.
REQ-012 IDLE: sel=0, req_out=0, ack_in=0.
REQ-013 IDLE, any req_in bit high at an edge:
- the block SHALL latch one winner into sel;
- it SHALL set req_out=1 and enter REQ.
REQ-014 Arbitration SHALL be round-robin. The search SHALL start at pointer p and proceed upward modulo N. The first set bit wins.
REQ-015 Simultaneous requests SHALL resolve in the same cycle by REQ-014; exactly one sel bit SHALL be set.
REQ-016 REQ, ack_out=1: ack_in SHALL equal sel on the next cycle, and the FSM SHALL enter ACK.
REQ-017 ACK: the granted req_in bit falls:
- ack_in=0 and req_out=0 on the next cycle;
- enter REL.
REQ-018 REL: ack_out=0 at an edge:
- sel=0;
- p = (granted index + 1) mod N;
- enter IDLE.
REQ-019 While a grant is held (REQ, ACK, REL), sel SHALL stay constant. Changes on non-granted req_in bits SHALL be ignored, and their ack_in bits SHALL remain 0.
REQ-020 REQ, granted req_in bit falls before ack_out rises (abort): req_out=0 on the next cycle, ack_in stays 0, and the FSM enters REL.
REQ-021 REQ, granted req_in bit falls and ack_out rises on the same edge: the abort of REQ-020 SHALL take precedence.
REQ-022 At most one ack_in bit SHALL be high at any time.
REQ-023 An ack_in bit SHALL never be high unless the corresponding sel bit is high.
REQ-024 A new grant SHALL NOT be issued before the REL-to-IDLE transition. Minimum idle gap between transactions: one cycle in IDLE.

Reset
REQ-025 rst=0 SHALL immediately, without waiting for clk, force:
- state=IDLE, p=0;
- sel=0, req_out=0, ack_in=0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction; no acknowledge SHALL be produced afterwards for it.
REQ-027 After rst returns to 1, the first rising clk edge SHALL evaluate req_in as in IDLE.

Verification (N=2)
REQ-028 Single request:
- rst pulse, req_in=01: next edge sel=01, req_out=1;
- ack_out=1: next edge ack_in=01;
- req_in=00: next edge ack_in=00, req_out=0;
- ack_out=0: next edge sel=00.
REQ-029 Simultaneous requests after reset: req_in=11 -> sel=01 first. After that transaction completes with req_in[1] still high -> next grant sel=10.
REQ-030 Fairness: req_in=11 held through repeated full handshakes -> sel alternates 01, 10, 01, ...
REQ-031 Lock: during an 01 grant, req_in[1] toggles -> sel stays 01 and ack_in[1] stays 0.
REQ-032 Abort: req_in=01 granted, req_in=00 before ack_out -> req_out=0 next cycle, ack_in never 01.
REQ-033 Asynchronous reset: rst=0 while in ACK -> sel, req_out and ack_in are 0 before the next clk edge.

Source files
------------

// File: rtl/arbiter_cascade.sv
// arbiter_cascade: round-robin N-to-1 four-phase handshake arbiter with registered outputs.
module arbiter_cascade #(
  parameter int input_size = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [input_size-1:0] req_in,
  output logic [input_size-1:0] ack_in,
  output logic                  req_out,
  input  logic                  ack_out,
  output logic [input_size-1:0] sel
);
  localparam int N  = input_size;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;
  state_t         state_q, state_d;
  logic [N-1:0]   sel_q, sel_d, ack_in_q, ack_in_d, win;
  logic           req_out_q, req_out_d, found, held;
  logic [IW-1:0]  p_q, p_d, idx_q, idx_d, win_idx;
  always_comb begin
    win = '0;
    win_idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_in[(int'(p_q) + k) % N]) begin
        found = 1'b1;
        win[(int'(p_q) + k) % N] = 1'b1;
        win_idx = IW'((int'(p_q) + k) % N);
      end
    end
  end
  assign held = |(req_in & sel_q);
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    ack_in_d = ack_in_q;
    req_out_d = req_out_q;
    p_d = p_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (found) begin
        sel_d = win;
        idx_d = win_idx;
        req_out_d = 1'b1;
        state_d = REQ;
      end
      // a dropped request beats a simultaneous ack_out (abort wins)
      REQ: if (!held) begin
        req_out_d = 1'b0;
        state_d = REL;
      end else if (ack_out) begin
        ack_in_d = sel_q;
        state_d = ACK;
      end
      ACK: if (!held) begin
        ack_in_d = '0;
        req_out_d = 1'b0;
        state_d = REL;
      end
      REL: if (!ack_out) begin
        sel_d = '0;
        p_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      ack_in_q <= '0;
      req_out_q <= 1'b0;
      p_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ack_in_q <= ack_in_d;
      req_out_q <= req_out_d;
      p_q <= p_d;
      idx_q <= idx_d;
    end
  end
  assign sel = sel_q;
  assign ack_in = ack_in_q;
  assign req_out = req_out_q;
endmodule

// File: tb/tb_arbiter_cascade.sv
// tb_arbiter_cascade: directed vector table plus async-reset sequence for N=2.
module tb_arbiter_cascade;
  logic clk = 1'b0, rst = 1'b0, req_out, ack_out = 1'b0;
  logic [1:0] req_in = 2'b00, ack_in, sel;
  int tests = 0, fails = 0;
  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       ack;
    logic [1:0] sel;
    logic       ro;
    logic [1:0] ai;
  } vec_t;
  vec_t v [35];
  arbiter_cascade #(.input_size(2)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in),
    .req_out(req_out), .ack_out(ack_out), .sel(sel)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [1:0] es, input logic er, input logic [1:0] ea);
    tests++;
    if (sel !== es || req_out !== er || ack_in !== ea) begin
      fails++;
      $display("FAIL %s: sel=%b req_out=%b ack_in=%b, expected sel=%b req_out=%b ack_in=%b",
               name, sel, req_out, ack_in, es, er, ea);
    end
  endtask
  initial begin
    v[0]  = '{1, 2'b01, 0, 2'b01, 1, 2'b00};
    v[1]  = '{1, 2'b01, 1, 2'b01, 1, 2'b01};
    v[2]  = '{1, 2'b00, 1, 2'b01, 0, 2'b00};
    v[3]  = '{1, 2'b00, 0, 2'b00, 0, 2'b00};
    v[4]  = '{0, 2'b00, 0, 2'b00, 0, 2'b00};
    v[5]  = '{1, 2'b11, 0, 2'b01, 1, 2'b00};
    v[6]  = '{1, 2'b01, 0, 2'b01, 1, 2'b00};
    v[7]  = '{1, 2'b11, 1, 2'b01, 1, 2'b01};
    v[8]  = '{1, 2'b01, 1, 2'b01, 1, 2'b01};
    v[9]  = '{1, 2'b10, 1, 2'b01, 0, 2'b00};
    v[10] = '{1, 2'b10, 0, 2'b00, 0, 2'b00};
    v[11] = '{1, 2'b11, 0, 2'b10, 1, 2'b00};
    v[12] = '{1, 2'b11, 1, 2'b10, 1, 2'b10};
    v[13] = '{1, 2'b01, 1, 2'b10, 0, 2'b00};
    v[14] = '{1, 2'b11, 0, 2'b00, 0, 2'b00};
    v[15] = '{1, 2'b11, 0, 2'b01, 1, 2'b00};
    v[16] = '{1, 2'b11, 1, 2'b01, 1, 2'b01};
    v[17] = '{1, 2'b10, 1, 2'b01, 0, 2'b00};
    v[18] = '{1, 2'b11, 0, 2'b00, 0, 2'b00};
    v[19] = '{1, 2'b11, 0, 2'b10, 1, 2'b00};
    v[20] = '{1, 2'b11, 1, 2'b10, 1, 2'b10};
    v[21] = '{1, 2'b01, 1, 2'b10, 0, 2'b00};
    v[22] = '{1, 2'b00, 0, 2'b00, 0, 2'b00};
    v[23] = '{1, 2'b01, 0, 2'b01, 1, 2'b00};
    v[24] = '{1, 2'b00, 0, 2'b01, 0, 2'b00};
    v[25] = '{1, 2'b00, 0, 2'b00, 0, 2'b00};
    v[26] = '{1, 2'b10, 0, 2'b10, 1, 2'b00};
    v[27] = '{1, 2'b00, 1, 2'b10, 0, 2'b00};
    v[28] = '{1, 2'b00, 1, 2'b10, 0, 2'b00};
    v[29] = '{1, 2'b00, 0, 2'b00, 0, 2'b00};
    v[30] = '{1, 2'b10, 0, 2'b10, 1, 2'b00};
    v[31] = '{1, 2'b00, 0, 2'b10, 0, 2'b00};
    v[32] = '{1, 2'b00, 0, 2'b00, 0, 2'b00};
    v[33] = '{1, 2'b11, 0, 2'b01, 1, 2'b00};
    v[34] = '{0, 2'b11, 0, 2'b00, 0, 2'b00};
    repeat (3) @(posedge clk);
    #1 check("reset", 2'b00, 1'b0, 2'b00);
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      rst = v[i].rst;
      req_in = v[i].req;
      ack_out = v[i].ack;
      if (!v[i].rst) #1;
      else begin
        @(posedge clk);
        #1;
      end
      check($sformatf("vec%0d", i), v[i].sel, v[i].ro, v[i].ai);
    end
    @(negedge clk);
    rst = 1'b1;
    req_in = 2'b01;
    ack_out = 1'b0;
    @(posedge clk);
    #1 check("ar_req", 2'b01, 1'b1, 2'b00);
    @(negedge clk);
    ack_out = 1'b1;
    @(posedge clk);
    #1 check("ar_ack", 2'b01, 1'b1, 2'b01);
    #2 rst = 1'b0;
    #1 check("ar_async", 2'b00, 1'b0, 2'b00);
    @(posedge clk);
    #1 check("ar_hold", 2'b00, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("ar_regrant", 2'b01, 1'b1, 2'b00);
    @(posedge clk);
    #1 check("ar_noack", 2'b01, 1'b1, 2'b01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
